ps2_ascii_decoder: RTL and testbench
====================================

# ps2_ascii_decoder

Sequential PS/2 set-2 scan-code-to-ASCII decoder with a prefix-tracking FSM, modifier state and a parametrised output FIFO. It sits between the PS/2 receiver, which delivers one-cycle `scan_valid` strobes per received byte, and the BRAM write or UART logic, which drains ASCII bytes through a valid/ready handshake. It decodes make codes for letters, digits, space, enter and backspace, and handles the E0 (extended) and F0 (break) prefixes.

## Interface
- `DEPTH`, default 8: FIFO entries. Must be a power of 2 and at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of `fifo_count`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `scan_valid` in 1: one-cycle strobe. Qualifies `scan_code`.
- `scan_code` in 8: raw set-2 byte from the receiver.
- `ascii` out 8: head-of-FIFO byte. Reads 8'h00 when the FIFO is empty.
- `ascii_valid` out 1: FIFO non-empty.
- `ascii_ready` in 1: consumer accepts the head byte when `ascii_valid && ascii_ready`.
- `fifo_count` out CW: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky flag. Set when a decoded byte is dropped because the FIFO is full.
- `shift_active` out 1: left or right shift is held.
- `caps_active` out 1: caps-lock toggle state.

## Operation
FSM states and transitions. Each transition happens on a `scan_valid` cycle only.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - Any other code is a make: process it and stay in IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - Any other code is an extended make. Discard it and return to IDLE.
- BRK: any code is a break. Apply modifier release and return to IDLE.
- EXT_BRK: any code is discarded. Return to IDLE.
- A repeated E0 in EXT, or F0 in BRK, does not change state.

Make processing in IDLE:
- 12 or 59 (shift) sets the shift-held bit for that key. The left and right bits are tracked separately. `shift_active` is their OR.
- 58 (caps) toggles `caps_active` only if `caps_held` is 0, then sets `caps_held`. Typematic repeats therefore do not re-toggle.
- The mapped codes below push exactly one byte. All unmapped codes push nothing.

Break processing:
- F0 12 or F0 59 clears the matching shift bit.
- F0 58 clears `caps_held`.
- Other breaks push nothing.

Map:
- Letters A-Z (set-2 codes): 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Digits 0-9: 45 16 1E 26 25 2E 36 3D 3E 46, mapped to 0x30-0x39. Digits are unaffected by modifiers.
- 29 maps to 0x20, 5A maps to 0x0D, 66 maps to 0x08.
- Letter case is set by the Configuration section.

FIFO:
- First-word-fall-through: `ascii` is the head entry, combinationally from storage.
- Pop happens on `ascii_valid && ascii_ready`.
- Pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- Full with push and no pop: the byte is dropped, `overflow` is set to 1, and occupancy is unchanged.
- Full with push and pop in the same cycle: both are accepted and the count stays DEPTH.
- Empty with push and pop: the pop is ignored (`ascii_valid` is 0) and the push is accepted.

## Timing
- Reset values, applied at the first clock edge with `rst` high:
  - FSM in IDLE.
  - `fifo_count` = 0, `ascii_valid` = 0, `ascii` = 8'h00.
  - `overflow` = 0, `shift_active` = 0, `caps_active` = 0, `caps_held` = 0.
- A reset during a prefix sequence (for example after E0) abandons it. The next byte is decoded from IDLE.
- Latency: a mapped make strobed in cycle N is written at the edge ending N.
  - If the FIFO was empty, `ascii_valid` = 1 with the byte on `ascii` in cycle N+1.
- Modifiers update at the same edge that consumes the scan byte. Case for a letter strobed in cycle N uses the modifier state registered before N.
- `scan_valid` may be high on consecutive cycles; every cycle is consumed. There is no back-pressure on the scan side.
- `overflow` clears only on `rst`.

## Configuration
- `PS2_ASCII_SHIFT_EN` defined:
  - Shift, caps and caps_held tracking are present.
  - A letter is uppercase (0x41-0x5A) when `shift_active ^ caps_active` is 1, otherwise lowercase (0x61-0x7A).
- `PS2_ASCII_SHIFT_EN` not defined:
  - No modifier registers exist.
  - `shift_active` and `caps_active` are tied to 0.
  - Letters are always uppercase (0x41-0x5A).
  - 12, 59 and 58 are treated as unmapped codes.

## Test plan
- Reset, then strobe 1C with `ascii_ready` = 0:
  - Cycle after the strobe: `ascii_valid` = 1, `fifo_count` = 1.
  - `ascii` = 0x61 with the macro, 0x41 without.
- Strobe sequence 12, 32, F0 12, 32 with `ascii_ready` = 1 (macro on):
  - Outputs in order: 0x42 then 0x62.
  - `shift_active` reads 1, then 0.
- Strobe sequence 58, 58, F0 58, 1C (macro on):
  - `caps_active` = 1 after the first 58 and stays 1 through the repeat.
  - The letter reads 0x41.
- Strobe sequence E0 75, E0 F0 75, F0 1C, 45:
  - Only 0x30 is output.
  - FSM is back in IDLE after each prefix sequence.
- Hold `ascii_ready` = 0 and push DEPTH+1 letters:
  - `fifo_count` saturates at 8 and `overflow` = 1.
  - The first 8 bytes drain in order.
  - With the FIFO full and `ascii_ready` = 1, a new strobe keeps the count at 8.
- Assert `rst` after strobing E0, then strobe 1C:
  - The byte is decoded as a normal make.
  - The FIFO holds only the new letter and `overflow` = 0.

Source files
------------

// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder: PS/2 set-2 scan-code to ASCII decoder.
// Prefix FSM (E0 / F0), optional modifier tracking and a first-word-fall-through
// output FIFO drained through a valid/ready handshake.
// Optional feature macro: PS2_ASCII_SHIFT_EN (shift / caps-lock letter case).
// Without it letters are always uppercase and the modifier outputs read 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no prefix pending; a non-prefix byte is a make code
// S_EXT     | E0 seen; next non-prefix byte is an extended make (dropped)
// S_BRK     | F0 seen; next non-F0 byte is a break (modifier release)
// S_EXT_BRK | E0 F0 seen; next byte is an extended break (dropped)
module ps2_ascii_decoder #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_valid,
    input  logic [7:0]    scan_code,
    output logic [7:0]    ascii,
    output logic          ascii_valid,
    input  logic          ascii_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          shift_active,
    output logic          caps_active
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        make_evt;
    logic        brk_evt;
    logic        upper;
    logic [8:0]  mapped;
    logic        push;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] occ;
    logic [7:0]  mem [DEPTH];

    // Map a make code to {hit, byte}. Letters use the case selected by 'up'.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic up);
        logic       is_letter;
        logic [7:0] idx;
        logic [7:0] base;
        map_code  = 9'h000;
        is_letter = 1'b1;
        idx       = 8'd0;
        case (code)
            8'h1C: idx = 8'd0;
            8'h32: idx = 8'd1;
            8'h21: idx = 8'd2;
            8'h23: idx = 8'd3;
            8'h24: idx = 8'd4;
            8'h2B: idx = 8'd5;
            8'h34: idx = 8'd6;
            8'h33: idx = 8'd7;
            8'h43: idx = 8'd8;
            8'h3B: idx = 8'd9;
            8'h42: idx = 8'd10;
            8'h4B: idx = 8'd11;
            8'h3A: idx = 8'd12;
            8'h31: idx = 8'd13;
            8'h44: idx = 8'd14;
            8'h4D: idx = 8'd15;
            8'h15: idx = 8'd16;
            8'h2D: idx = 8'd17;
            8'h1B: idx = 8'd18;
            8'h2C: idx = 8'd19;
            8'h3C: idx = 8'd20;
            8'h2A: idx = 8'd21;
            8'h1D: idx = 8'd22;
            8'h22: idx = 8'd23;
            8'h35: idx = 8'd24;
            8'h1A: idx = 8'd25;
            default: is_letter = 1'b0;
        endcase
        base = up ? 8'h41 : 8'h61;
        if (is_letter) begin
            map_code = {1'b1, base + idx};
        end else begin
            case (code)
                8'h45: map_code = {1'b1, 8'h30};
                8'h16: map_code = {1'b1, 8'h31};
                8'h1E: map_code = {1'b1, 8'h32};
                8'h26: map_code = {1'b1, 8'h33};
                8'h25: map_code = {1'b1, 8'h34};
                8'h2E: map_code = {1'b1, 8'h35};
                8'h36: map_code = {1'b1, 8'h36};
                8'h3D: map_code = {1'b1, 8'h37};
                8'h3E: map_code = {1'b1, 8'h38};
                8'h46: map_code = {1'b1, 8'h39};
                8'h29: map_code = {1'b1, 8'h20};
                8'h5A: map_code = {1'b1, 8'h0D};
                8'h66: map_code = {1'b1, 8'h08};
                default: map_code = 9'h000;
            endcase
        end
    endfunction

    // Prefix FSM state register; reset abandons any partial prefix sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Prefix FSM next state and make/break event decode.
    always_comb begin
        state_nxt = state;
        make_evt  = 1'b0;
        brk_evt   = 1'b0;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == CODE_EXT) begin
                        state_nxt = S_EXT;
                    end else if (scan_code == CODE_BRK) begin
                        state_nxt = S_BRK;
                    end else begin
                        make_evt = 1'b1;
                    end
                end
                S_EXT: begin
                    if (scan_code == CODE_BRK) begin
                        state_nxt = S_EXT_BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (scan_code == CODE_BRK) begin
                        state_nxt = S_BRK;
                    end else begin
                        state_nxt = S_IDLE;
                        brk_evt   = 1'b1;
                    end
                end
                S_EXT_BRK: state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef PS2_ASCII_SHIFT_EN
    logic shift_l;
    logic shift_r;
    logic caps;
    logic caps_held;

    // Modifier tracking; caps only toggles on the first make of a hold so
    // typematic repeats leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (make_evt) begin
            case (scan_code)
                CODE_LSHIFT: shift_l <= 1'b1;
                CODE_RSHIFT: shift_r <= 1'b1;
                CODE_CAPS: begin
                    if (!caps_held) begin
                        caps <= ~caps;
                    end
                    caps_held <= 1'b1;
                end
                default: ;
            endcase
        end else if (brk_evt) begin
            case (scan_code)
                CODE_LSHIFT: shift_l   <= 1'b0;
                CODE_RSHIFT: shift_r   <= 1'b0;
                CODE_CAPS:   caps_held <= 1'b0;
                default: ;
            endcase
        end
    end

    assign shift_active = shift_l | shift_r;
    assign caps_active  = caps;
    assign upper        = shift_active ^ caps_active;
`else
    // Breaks only matter for modifier release, which is absent in this build.
    logic unused_brk;
    assign unused_brk   = brk_evt;
    assign shift_active = 1'b0;
    assign caps_active  = 1'b0;
    assign upper        = 1'b1;
`endif

    assign mapped      = map_code(scan_code, upper);
    assign push        = make_evt & mapped[8];
    assign occ         = wr_ptr - rd_ptr;
    assign full        = (occ == FULL_OCC);
    assign ascii_valid = (occ != '0);
    assign pop         = ascii_valid & ascii_ready;
    assign push_ok     = push & (~full | pop);
    assign fifo_count  = CW'(occ);
    assign ascii       = ascii_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // FIFO pointers and sticky overflow; a full FIFO still accepts a push
    // when the head is being popped in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= mapped[7:0];
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb_ps2_ascii_decoder: directed scenarios plus randomized scan traffic checked
// every cycle against a queue-based reference model of the decoder.
module tb_ps2_ascii_decoder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scan_valid = 1'b0;
    logic [7:0]    scan_code = 8'h00;
    logic [7:0]    ascii;
    logic          ascii_valid;
    logic          ascii_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          shift_active;
    logic          caps_active;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_ascii_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .ascii        (ascii),
        .ascii_valid  (ascii_valid),
        .ascii_ready  (ascii_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .shift_active (shift_active),
        .caps_active  (caps_active)
    );

    // Reference model state
    byte unsigned mq[$];
    bit m_ovf;
    bit m_ext;
    bit m_brk;
`ifdef PS2_ASCII_SHIFT_EN
    bit m_sl;
    bit m_sr;
    bit m_caps;
    bit m_caps_held;
`endif

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_map(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == c) return (up ? 65 : 97) + i;
        end
        for (int i = 0; i < 10; i++) begin
            if (digit_codes[i] == c) return 48 + i;
        end
        if (c == 8'h29) return 32;
        if (c == 8'h5A) return 13;
        if (c == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_ext = 0;
        m_brk = 0;
`ifdef PS2_ASCII_SHIFT_EN
        m_sl = 0;
        m_sr = 0;
        m_caps = 0;
        m_caps_held = 0;
`endif
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit sv, input logic [7:0] c, input bit rdy);
        bit pop;
        bit up;
        bit is_make;
        bit is_break;
        int b;
        pop = (mq.size() > 0) && rdy;
        b = -1;
        is_make = 0;
        is_break = 0;
`ifdef PS2_ASCII_SHIFT_EN
        up = (m_sl | m_sr) ^ m_caps;
`else
        up = 1;
`endif
        if (sv) begin
            if (m_ext && m_brk) begin
                m_ext = 0;
                m_brk = 0;
            end else if (m_ext) begin
                if (c == 8'hF0) m_brk = 1;
                else if (c != 8'hE0) m_ext = 0;
            end else if (m_brk) begin
                if (c != 8'hF0) begin
                    m_brk = 0;
                    is_break = 1;
                end
            end else begin
                if (c == 8'hE0) m_ext = 1;
                else if (c == 8'hF0) m_brk = 1;
                else is_make = 1;
            end
        end
        if (is_make) b = model_map(c, up);
`ifdef PS2_ASCII_SHIFT_EN
        if (is_make) begin
            if (c == 8'h12) m_sl = 1;
            if (c == 8'h59) m_sr = 1;
            if (c == 8'h58) begin
                if (!m_caps_held) m_caps = !m_caps;
                m_caps_held = 1;
            end
        end
        if (is_break) begin
            if (c == 8'h12) m_sl = 0;
            if (c == 8'h59) m_sr = 0;
            if (c == 8'h58) m_caps_held = 0;
        end
`else
        if (is_break) b = -1;
`endif
        if (b >= 0 && mq.size() == DEPTH && !pop) begin
            m_ovf = 1;
            b = -1;
        end
        if (pop) void'(mq.pop_front());
        if (b >= 0) mq.push_back(byte'(b));
    endtask

    task automatic check_outputs(input string tag);
        int exp_ascii;
        exp_ascii = (mq.size() > 0) ? int'(mq[0]) : 0;
        chk({tag, "_valid"}, 32'(ascii_valid), 32'(mq.size() > 0));
        chk({tag, "_ascii"}, 32'(ascii), 32'(exp_ascii));
        chk({tag, "_count"}, 32'(fifo_count), 32'(mq.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef PS2_ASCII_SHIFT_EN
        chk({tag, "_shift"}, 32'(shift_active), 32'(m_sl | m_sr));
        chk({tag, "_caps"}, 32'(caps_active), 32'(m_caps));
`else
        chk({tag, "_shift"}, 32'(shift_active), 32'd0);
        chk({tag, "_caps"}, 32'(caps_active), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_valid = 1'b0;
        ascii_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    task automatic cycle(input bit sv, input logic [7:0] c, input bit rdy, input string tag);
        scan_valid = sv;
        scan_code = c;
        ascii_ready = rdy;
        @(posedge clk);
        #1;
        model_step(sv, c, rdy);
        check_outputs(tag);
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 40) return letter_codes[$urandom_range(0, 25)];
        if (r < 55) return digit_codes[$urandom_range(0, 9)];
        if (r < 58) return 8'h29;
        if (r < 60) return (r == 58) ? 8'h5A : 8'h66;
        if (r < 66) return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        if (r < 72) return 8'h58;
        if (r < 81) return 8'hE0;
        if (r < 92) return 8'hF0;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] lc;
        // Single make into an empty FIFO
        do_reset();
        cycle(1, 8'h1C, 0, "t1");
`ifdef PS2_ASCII_SHIFT_EN
        chk("t1_letter", 32'(ascii), 32'h61);
`else
        chk("t1_letter", 32'(ascii), 32'h41);
`endif
        chk("t1_cnt", 32'(fifo_count), 32'd1);

        // Shift make / break around a letter
        do_reset();
        cycle(1, 8'h12, 1, "t2");
`ifdef PS2_ASCII_SHIFT_EN
        chk("t2_shift_on", 32'(shift_active), 32'd1);
`endif
        cycle(1, 8'h32, 1, "t2");
        chk("t2_first", 32'(ascii), 32'h42);
        cycle(1, 8'hF0, 1, "t2");
        cycle(1, 8'h12, 1, "t2");
        chk("t2_shift_off", 32'(shift_active), 32'd0);
        cycle(1, 8'h32, 1, "t2");
`ifdef PS2_ASCII_SHIFT_EN
        chk("t2_second", 32'(ascii), 32'h62);
`else
        chk("t2_second", 32'(ascii), 32'h42);
`endif

        // Caps lock with typematic repeat
        do_reset();
        cycle(1, 8'h58, 0, "t3");
`ifdef PS2_ASCII_SHIFT_EN
        chk("t3_caps1", 32'(caps_active), 32'd1);
`endif
        cycle(1, 8'h58, 0, "t3");
`ifdef PS2_ASCII_SHIFT_EN
        chk("t3_caps2", 32'(caps_active), 32'd1);
`endif
        cycle(1, 8'hF0, 0, "t3");
        cycle(1, 8'h58, 0, "t3");
        cycle(1, 8'h1C, 0, "t3");
        chk("t3_letter", 32'(ascii), 32'h41);

        // Extended and break prefixes
        do_reset();
        cycle(1, 8'hE0, 0, "t4");
        cycle(1, 8'h75, 0, "t4");
        cycle(1, 8'hE0, 0, "t4");
        cycle(1, 8'hF0, 0, "t4");
        cycle(1, 8'h75, 0, "t4");
        cycle(1, 8'hF0, 0, "t4");
        cycle(1, 8'h1C, 0, "t4");
        chk("t4_empty", 32'(fifo_count), 32'd0);
        cycle(1, 8'h45, 0, "t4");
        chk("t4_cnt", 32'(fifo_count), 32'd1);
        chk("t4_digit", 32'(ascii), 32'h30);

        // Overflow, full push-with-pop, drain
        do_reset();
        for (int i = 0; i <= DEPTH; i++) cycle(1, letter_codes[i], 0, "t5");
        chk("t5_full", 32'(fifo_count), 32'(DEPTH));
        chk("t5_ovf", 32'(overflow), 32'd1);
        cycle(1, letter_codes[20], 1, "t5");
        chk("t5_full_pp", 32'(fifo_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 8'h00, 1, "t5_drain");
        chk("t5_drained", 32'(fifo_count), 32'd0);

        // Reset in the middle of a prefix sequence
        cycle(1, 8'h1C, 0, "t6");
        cycle(1, 8'hE0, 0, "t6");
        do_reset();
        cycle(1, 8'h1C, 0, "t6");
        chk("t6_cnt", 32'(fifo_count), 32'd1);
        chk("t6_ovf", 32'(overflow), 32'd0);

        // Randomized traffic with varying consumer pressure
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 1000; n++) begin
                lc = pick_code();
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    cycle($urandom_range(0, 3) != 0, lc, $urandom_range(0, 3) < ph, "rnd");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
